// File: rtl/ps2_pkg.sv
// Shared PS/2 constants and the frame-state type.
package ps2_pkg;

    localparam int unsigned PS2_DATA_BITS = 8;
    localparam int unsigned KEY_W         = 9;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [KEY_W-1:0] KEY_UP   = 9'h175;
    localparam logic [KEY_W-1:0] KEY_DOWN = 9'h172;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } frame_state_e;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 byte receiver: synchronisers, falling-edge detect, frame FSM and watchdog.
// byte_valid/frame_err are decoded from the detect cycle so the consumer can
// register its result on the same edge that samples the stop bit.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    output logic                     byte_valid,
    output logic [PS2_DATA_BITS-1:0] byte_data,
    output logic                     frame_err
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

    logic [1:0]               clk_sync_q;
    logic [1:0]               dat_sync_q;
    logic                     clk_prev_q;
    frame_state_e             state_q;
    logic [2:0]               bit_cnt_q;
    logic [PS2_DATA_BITS-1:0] shift_q;
    logic                     par_q;
    logic [CW-1:0]            wdog_q;

    logic fall_c;
    logic data_c;
    logic timeout_c;
    logic edge_c;
    logic odd_c;

    assign fall_c    = clk_prev_q & ~clk_sync_q[1];
    assign data_c    = dat_sync_q[1];
    assign timeout_c = (state_q != S_IDLE) && (wdog_q == TO_MAX);
    assign edge_c    = fall_c & ~timeout_c;
    assign odd_c     = ^{shift_q, par_q};

    // Two-flop synchronisers plus previous-clock flop; idle bus level is 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    // Frame FSM; the watchdog abort wins over a coincident edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= '0;
            par_q     <= 1'b0;
        end else if (timeout_c) begin
            state_q <= S_IDLE;
        end else if (fall_c) begin
            case (state_q)
                S_IDLE: begin
                    if (!data_c) begin
                        state_q   <= S_DATA;
                        bit_cnt_q <= 3'd0;
                    end
                end
                S_DATA: begin
                    shift_q   <= {data_c, shift_q[PS2_DATA_BITS-1:1]};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_q <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_q   <= data_c;
                    state_q <= S_STOP;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Saturating watchdog: cleared in IDLE and on every falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
        end else if ((state_q == S_IDLE) || fall_c) begin
            wdog_q <= '0;
        end else if (wdog_q != TO_MAX) begin
            wdog_q <= wdog_q + CW'(1);
        end
    end

    assign byte_data  = shift_q;
    assign byte_valid = edge_c && (state_q == S_STOP) && data_c && odd_c;
    assign frame_err  = timeout_c
                      || (edge_c && (state_q == S_IDLE) && data_c)
                      || (edge_c && (state_q == S_STOP) && !(data_c && odd_c));

endmodule

// File: rtl/ps2_keypad.sv
// PS/2 keyboard front end: E0/F0 prefix decoding and held/press/release
// tracking for a parameterised table of {ext, code} entries.
module ps2_keypad
    import ps2_pkg::*;
#(
    parameter int unsigned              N_KEYS         = 2,
    parameter logic [N_KEYS*KEY_W-1:0]  KEY_CODES      = {KEY_DOWN, KEY_UP},
    parameter int unsigned              TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    output logic                     code_valid,
    output logic [PS2_DATA_BITS-1:0] code,
    output logic                     code_ext,
    output logic                     code_brk,
    output logic [N_KEYS-1:0]        key_state,
    output logic [N_KEYS-1:0]        key_press,
    output logic [N_KEYS-1:0]        key_release,
    output logic                     frame_err
);

    logic                     rx_valid;
    logic [PS2_DATA_BITS-1:0] rx_byte;
    logic                     rx_err;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(rx_valid),
        .byte_data (rx_byte),
        .frame_err (rx_err)
    );

    logic                     ext_q, ext_d;
    logic                     brk_q, brk_d;
    logic                     code_valid_q, code_valid_d;
    logic [PS2_DATA_BITS-1:0] code_q, code_d;
    logic                     code_ext_q, code_ext_d;
    logic                     code_brk_q, code_brk_d;
    logic [N_KEYS-1:0]        key_state_q, key_state_d;
    logic [N_KEYS-1:0]        key_press_q, key_press_d;
    logic [N_KEYS-1:0]        key_release_q, key_release_d;
    logic                     frame_err_q, frame_err_d;

    // Prefix layer and key table next-state.
    always_comb begin
        ext_d         = ext_q;
        brk_d         = brk_q;
        code_valid_d  = 1'b0;
        code_d        = code_q;
        code_ext_d    = code_ext_q;
        code_brk_d    = code_brk_q;
        key_state_d   = key_state_q;
        key_press_d   = '0;
        key_release_d = '0;
        frame_err_d   = rx_err;

        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_d = 1'b1;
            end else begin
                code_valid_d = 1'b1;
                code_d       = rx_byte;
                code_ext_d   = ext_q;
                code_brk_d   = brk_q;
                ext_d        = 1'b0;
                brk_d        = 1'b0;
                for (int unsigned i = 0; i < N_KEYS; i++) begin
                    if (KEY_CODES[i*KEY_W +: KEY_W] == {ext_q, rx_byte}) begin
                        if (!brk_q && !key_state_q[i]) begin
                            key_state_d[i] = 1'b1;
                            key_press_d[i] = 1'b1;
                        end else if (brk_q && key_state_q[i]) begin
                            key_state_d[i]   = 1'b0;
                            key_release_d[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Output and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            code_valid_q  <= 1'b0;
            code_q        <= '0;
            code_ext_q    <= 1'b0;
            code_brk_q    <= 1'b0;
            key_state_q   <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
            frame_err_q   <= 1'b0;
        end else begin
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            code_valid_q  <= code_valid_d;
            code_q        <= code_d;
            code_ext_q    <= code_ext_d;
            code_brk_q    <= code_brk_d;
            key_state_q   <= key_state_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign code_valid  = code_valid_q;
    assign code        = code_q;
    assign code_ext    = code_ext_q;
    assign code_brk    = code_brk_q;
    assign key_state   = key_state_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_keypad.sv
// Scoreboard bench for ps2_keypad: stimulus pushes expected events computed
// from the keyboard protocol rules; a monitor pops on every output pulse.
module tb_ps2_keypad;

    localparam int unsigned NK = 3;
    localparam logic [NK*9-1:0] KC = {9'h01C, 9'h172, 9'h175};
    localparam int unsigned TO = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ps2_clk = 1'b1;
    logic          ps2_data = 1'b1;
    logic          code_valid;
    logic [7:0]    code;
    logic          code_ext;
    logic          code_brk;
    logic [NK-1:0] key_state;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          frame_err;

    always #5 clk = ~clk;

    ps2_keypad #(
        .N_KEYS        (NK),
        .KEY_CODES     (KC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code_valid (code_valid),
        .code       (code),
        .code_ext   (code_ext),
        .code_brk   (code_brk),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .frame_err  (frame_err)
    );

    typedef struct packed {
        logic          is_err;
        logic [7:0]    code;
        logic          ext;
        logic          brk;
        logic [NK-1:0] st;
        logic [NK-1:0] pr;
        logic [NK-1:0] rl;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int stop_cyc = 0;

    // Reference model: prefix flags and the set of currently held keys.
    logic          m_ext = 1'b0;
    logic          m_brk = 1'b0;
    logic [NK-1:0] m_held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] key_of(input int i);
        return KC[i*9 +: 9];
    endfunction

    task automatic model_err();
        ev_t e;
        e = '0;
        e.is_err = 1'b1;
        e.st = m_held;
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b);
        ev_t e;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            e = '0;
            e.code = b;
            e.ext = m_ext;
            e.brk = m_brk;
            for (int i = 0; i < NK; i++) begin
                if (key_of(i) == {m_ext, b}) begin
                    if (!m_brk && !m_held[i]) begin
                        m_held[i] = 1'b1;
                        e.pr[i] = 1'b1;
                    end else if (m_brk && m_held[i]) begin
                        m_held[i] = 1'b0;
                        e.rl[i] = 1'b1;
                    end
                end
            end
            e.st = m_held;
            m_ext = 1'b0;
            m_brk = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // One PS/2 bit: data set while clock high, then a low phase.
    task automatic ps2_bit(input logic b, input logic is_stop);
        ps2_data = b;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        if (is_stop) stop_cyc = cyc;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // mode 0 = good frame, 1 = bad parity, 2 = bad stop bit.
    task automatic tx(input logic [7:0] b, input int mode);
        logic par;
        par = ~(^b);
        if (mode == 1) par = ~par;
        if (mode == 0) model_byte(b);
        else model_err();
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit(par, 1'b0);
        ps2_bit((mode == 2) ? 1'b0 : 1'b1, 1'b1);
        ps2_data = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    function automatic int err_mode();
        int r;
        r = $urandom_range(0, 19);
        return (r == 0) ? 1 : ((r == 1) ? 2 : 0);
    endfunction

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " code_valid"}, 32'(code_valid), 0);
        chk({tag, " code"}, 32'(code), 0);
        chk({tag, " code_ext"}, 32'(code_ext), 0);
        chk({tag, " code_brk"}, 32'(code_brk), 0);
        chk({tag, " key_state"}, 32'(key_state), 0);
        chk({tag, " key_press"}, 32'(key_press), 0);
        chk({tag, " key_release"}, 32'(key_release), 0);
        chk({tag, " frame_err"}, 32'(frame_err), 0);
    endtask

    // Monitor: every output pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rst) begin
            if (code_valid || frame_err) begin
                n_cmp++;
                if (code_valid && frame_err) begin
                    n_fail++;
                    $display("FAIL both_pulses: got code_valid=1 frame_err=1 want only one");
                end else if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected: got code_valid=%0b frame_err=%0b code=%h want no event",
                             code_valid, frame_err, code);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.is_err ? !(frame_err && key_state == mon_e.st)
                                     : !(code_valid && code == mon_e.code && code_ext == mon_e.ext
                                         && code_brk == mon_e.brk && key_state == mon_e.st
                                         && key_press == mon_e.pr && key_release == mon_e.rl
                                         && (cyc - stop_cyc) == 3)) begin
                        n_fail++;
                        $display("FAIL event: got err=%0b code=%h ext=%0b brk=%0b st=%b pr=%b rl=%b lat=%0d want err=%0b code=%h ext=%0b brk=%0b st=%b pr=%b rl=%b lat=3",
                                 frame_err, code, code_ext, code_brk, key_state, key_press, key_release,
                                 cyc - stop_cyc, mon_e.is_err, mon_e.code, mon_e.ext, mon_e.brk,
                                 mon_e.st, mon_e.pr, mon_e.rl);
                    end
                end
            end else if (key_press != '0 || key_release != '0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL stray_key_pulse: got press=%b release=%b want 0 without code_valid",
                         key_press, key_release);
            end
        end
    end

    initial begin
        logic [8:0] kc;
        logic       brk;
        int         pick;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Up make, typematic repeat, break.
        tx(8'hE0, 0); tx(8'h75, 0);
        tx(8'hE0, 0); tx(8'h75, 0);
        tx(8'hE0, 0); tx(8'hF0, 0); tx(8'h75, 0);

        // Up held, down make then break.
        tx(8'hE0, 0); tx(8'h75, 0);
        tx(8'hE0, 0); tx(8'h72, 0);
        tx(8'hE0, 0); tx(8'hF0, 0); tx(8'h72, 0);

        // Parity error clears the pending E0.
        tx(8'hE0, 0); tx(8'h75, 1); tx(8'h72, 0);
        tx(8'hE0, 0); tx(8'h72, 0);

        // Stop-bit error clears the pending F0.
        tx(8'hF0, 0); tx(8'h33, 2); tx(8'h33, 0);

        // Start-bit error: a lone falling edge with data high.
        model_err();
        ps2_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        repeat (8) @(negedge clk);

        // Watchdog: E0, then a frame stalled after 4 data bits.
        tx(8'hE0, 0);
        model_err();
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
        ps2_data = 1'b1;
        repeat (TO + 30) @(negedge clk);
        tx(8'h1C, 0);

        // Reset mid-frame while keys are held.
        wait_drain();
        chk("drain_before_reset", 32'(exp_q.size()), 0);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
        rst = 1'b0;
        m_held = '0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("midreset");
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        tx(8'hE0, 0); tx(8'h72, 0);
        tx(8'h1C, 0);

        // Randomised key traffic with occasional corrupted frames.
        for (int it = 0; it < 80; it++) begin
            pick = $urandom_range(0, 4);
            case (pick)
                0: kc = 9'h175;
                1: kc = 9'h172;
                2: kc = 9'h01C;
                3: kc = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 8'hDF))};
                default: kc = 9'h000;
            endcase
            if (pick == 4) begin
                tx(8'($urandom_range(0, 255)), $urandom_range(1, 2));
            end else begin
                brk = 1'($urandom_range(0, 1));
                if (kc[8]) tx(8'hE0, err_mode());
                if (brk) tx(8'hF0, err_mode());
                tx(kc[7:0], err_mode());
            end
        end

        wait_drain();
        repeat (10) @(negedge clk);
        chk("final_drain", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
